mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the word-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 rN_req  in  1  (N=0,1) SHALL be the access request; held with fields stable until rN_gnt.
REQ-006 rN_we  in  1  SHALL select write (1) or read (0).
REQ-007 rN_addr  in  ADDR_W  SHALL be the word address.
REQ-008 rN_wdata  in  DATA_W  SHALL be the write data.
REQ-009 rN_gnt  out  1  SHALL be a one-cycle pulse marking the cycle the access reaches memory.
REQ-010 rN_rvalid  out  1  SHALL be a one-cycle pulse marking valid read data.
REQ-011 rN_rdata  out  DATA_W  SHALL carry the read data, held until that requester's next read completes.
REQ-012 mem_we  out  1  SHALL be the memory write enable.
REQ-013 mem_addr  out  ADDR_W  SHALL be the memory address.
REQ-014 mem_din  out  DATA_W  SHALL be the memory write data.
REQ-015 mem_dout  in  DATA_W  SHALL be the memory's combinational read data.

Function
REQ-016 FSM SHALL have states IDLE, ACCESS and RESP, with encoding from the package.
REQ-017 IDLE: when any rN_req=1, the arbiter SHALL latch the winner's id, we, addr and wdata, and go to ACCESS; otherwise it stays in IDLE.
REQ-018 ACCESS: mem_* SHALL be driven from the latched registers, the winner's rN_gnt SHALL be 1, and mem_we SHALL equal the latched we; next state is RESP.
REQ-019 mem_we SHALL be 0 in every state other than ACCESS; mem_addr/mem_din SHALL hold their last values outside ACCESS.
REQ-020 At the end of ACCESS on a read, mem_dout SHALL be registered into the winner's rN_rdata; rN_rvalid SHALL be 1 during RESP.
REQ-021 A write SHALL produce no rvalid pulse.
REQ-022 RESP SHALL always go to IDLE, giving a 3-cycle request-to-rvalid latency and at most one access per 3 cycles.
REQ-023 Requests arriving in ACCESS or RESP SHALL NOT be sampled; they are handled on the next IDLE.
REQ-024 Once latched, an access SHALL complete even if rN_req drops.
REQ-025 Fixed priority (default): on simultaneous requests, r0 SHALL win.
REQ-026 The non-granted rN_gnt and rN_rvalid SHALL stay 0.

Reset
REQ-027 rst_n=0 SHALL immediately force: state=IDLE, mem_we=0, mem_addr=0, mem_din=0, all rN_gnt=0, all rN_rvalid=0, all rN_rdata=0, and last-grant pointer=1.
REQ-028 Reset asserted during ACCESS SHALL abort the write without a memory update after the asynchronous assertion.
REQ-029 The first IDLE sample SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-030 With MEM_ARB_RR_EN defined, contention SHALL be resolved round-robin: the requester not granted last wins, and the last-grant pointer updates on entry to ACCESS.
REQ-031 Without MEM_ARB_RR_EN, REQ-025 fixed priority SHALL apply and no pointer register SHALL exist.

Structure
REQ-032 Package mem_arb_pkg SHALL hold ADDR_W/DATA_W defaults, the state enum and the requester-id type.
REQ-033 Winner selection SHALL be a sub-module arb_pick: inputs req[1:0] and last; output the winner id.

Verification
REQ-034 r1 write addr 0x010, data 0xDEADBEEF, followed by r0 read of 0x010 -> r1_gnt 1 cycle, mem_we pulses once, then r0_rvalid with r0_rdata=0xDEADBEEF.
REQ-035 Both requesters read in the same cycle, no macro -> r0 is served first; r1 is served on the next IDLE; the r1 rvalid arrives 3 cycles after the r0 rvalid.
REQ-036 With MEM_ARB_RR_EN, both requesters hold req for 6 accesses -> grants alternate r0,r1,r0,r1,r0,r1.
REQ-037 rst_n pulled low in ACCESS of a write to 0xFFF -> mem_we falls immediately and the location keeps its old value.
REQ-038 r0 read of addr 0xFFF preloaded with 0x12345678 -> rvalid 3 cycles after req, and r1_rdata is unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: default widths,
// the FSM state encoding and the requester-id type.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    // One bit identifies which of the two requesters owns an access.
    typedef logic req_id_t;

    localparam req_id_t ID_R0 = 1'b0;
    localparam req_id_t ID_R1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Winner selection for the memory arbiter.
// Default build: fixed priority, requester 0 wins any contention.
// With MEM_ARB_RR_EN defined: round-robin, the requester not granted last wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output req_id_t    winner
);

`ifdef MEM_ARB_RR_EN
    // Alternate on contention; a lone requester always wins.
    always_comb begin
        if (req[0] && req[1]) winner = ~last;
        else                  winner = req[1] ? ID_R1 : ID_R0;
    end
`else
    // Requester 1 only wins when requester 0 is silent.
    assign winner = (req[1] && !req[0]) ? ID_R1 : ID_R0;

    // The pointer input is meaningless under fixed priority.
    logic unused_last;
    assign unused_last = last;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory with combinational
// read data. Each access runs IDLE -> ACCESS -> RESP, so a request sampled in
// IDLE reaches memory in the next cycle and read data is valid the cycle after.
// Optional feature: define MEM_ARB_RR_EN for round-robin contention handling.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_t            state;
    req_id_t           id_q;
    logic              we_q;
    req_id_t           pick;
    req_id_t           last;
    logic              any_req;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign any_req   = r0_req | r1_req;
    assign sel_we    = (pick == ID_R1) ? r1_we    : r0_we;
    assign sel_addr  = (pick == ID_R1) ? r1_addr  : r0_addr;
    assign sel_wdata = (pick == ID_R1) ? r1_wdata : r0_wdata;

    arb_pick u_pick (
        .req    ({r1_req, r0_req}),
        .last   (last),
        .winner (pick)
    );

`ifdef MEM_ARB_RR_EN
    req_id_t last_q;

    // Remember who was granted, updated as the access enters ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        last_q <= ID_R1;
        else if (state == IDLE && any_req) last_q <= pick;
    end

    assign last = last_q;
`else
    assign last = ID_R1;
`endif

    // Access sequencer; mem_addr/mem_din double as the latched address and
    // write data, so they naturally hold their value outside ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here uses <= so all of them update from the
        // same pre-edge values; blocking = would leak new values mid-block.
        if (!rst_n) begin
            state     <= IDLE;
            id_q      <= ID_R0;
            we_q      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            r0_gnt    <= 1'b0;
            r1_gnt    <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        id_q     <= pick;
                        we_q     <= sel_we;
                        mem_we   <= sel_we;
                        mem_addr <= sel_addr;
                        mem_din  <= sel_wdata;
                        r0_gnt   <= (pick == ID_R0);
                        r1_gnt   <= (pick == ID_R1);
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    r0_gnt <= 1'b0;
                    r1_gnt <= 1'b0;
                    if (!we_q) begin
                        if (id_q == ID_R0) begin
                            r0_rdata  <= mem_dout;
                            r0_rvalid <= 1'b1;
                        end else begin
                            r1_rdata  <= mem_dout;
                            r1_rvalid <= 1'b1;
                        end
                    end
                    state <= RESP;
                end
                RESP: begin
                    r0_rvalid <= 1'b0;
                    r1_rvalid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural memory.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_req, r0_we, r1_req, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;
    int we_pulses = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Single-port memory: synchronous write, combinational read.
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;
    assign mem_dout = mem[mem_addr];

    always @(posedge clk) if (mem_we) we_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, n, both;
        int seq [6];
        int exp_seq [6];

        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        mem[12'h020] = 32'h0000_AAAA;
        mem[12'h030] = 32'h0000_BBBB;
        mem[12'hFFF] = 32'h1234_5678;

        r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;

        // ---- reset state
        rst_n = 1'b0;
        #1;
        check("rst_mem_we",    mem_we,    0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_din",   mem_din,   0);
        check("rst_gnt",       {r1_gnt, r0_gnt}, 0);
        check("rst_rvalid",    {r1_rvalid, r0_rvalid}, 0);
        check("rst_r0_rdata",  r0_rdata,  0);
        check("rst_r1_rdata",  r1_rdata,  0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---- r1 write 0x010 then r0 read 0x010
        we_pulses = 0;
        r1_req = 1; r1_we = 1; r1_addr = 12'h010; r1_wdata = 32'hDEAD_BEEF;
        tick();                                  // ACCESS
        check("wr_r1_gnt",    r1_gnt,   1);
        check("wr_r0_gnt",    r0_gnt,   0);
        check("wr_mem_we",    mem_we,   1);
        check("wr_mem_addr",  mem_addr, 12'h010);
        check("wr_mem_din",   mem_din,  32'hDEAD_BEEF);
        r1_req = 0;
        r0_req = 1; r0_we = 0; r0_addr = 12'h010;  // arrives in ACCESS
        tick();                                  // RESP
        check("wr_r1_gnt_pulse", r1_gnt, 0);
        check("wr_no_rvalid", {r1_rvalid, r0_rvalid}, 0);
        check("wr_mem_we_off", mem_we, 0);
        check("wr_mem_hold",  mem_addr, 12'h010);
        check("wr_mem_data",  mem[12'h010], 32'hDEAD_BEEF);
        tick();                                  // IDLE, not yet sampled
        check("rd_no_early_gnt", r0_gnt, 0);
        tick();                                  // ACCESS
        check("rd_r0_gnt",    r0_gnt,   1);
        check("rd_mem_we",    mem_we,   0);
        r0_req = 0;
        tick();                                  // RESP
        check("rd_r0_rvalid", r0_rvalid, 1);
        check("rd_r0_rdata",  r0_rdata, 32'hDEAD_BEEF);
        check("rd_r1_rvalid", r1_rvalid, 0);
        check("wr_we_pulses", we_pulses, 1);
        tick();                                  // IDLE
        check("rd_rvalid_pulse", r0_rvalid, 0);

        // ---- simultaneous reads, r0 first under either policy (pointer=r1)
        r0_req = 1; r0_we = 0; r0_addr = 12'h020;
        r1_req = 1; r1_we = 0; r1_addr = 12'h030;
        t0 = -1; t1 = -1; both = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick();
            if (r0_gnt && r1_gnt) both++;
            if (r0_gnt) r0_req = 0;
            if (r1_gnt) r1_req = 0;
            if (r0_rvalid && t0 < 0) t0 = cyc;
            if (r1_rvalid && t1 < 0) t1 = cyc;
            if (r0_rvalid && r1_rvalid) both++;
        end
        check("sim_r0_rvalid_cyc", t0, 2);
        check("sim_r1_rvalid_cyc", t1, 5);
        check("sim_rvalid_gap",    t1 - t0, 3);
        check("sim_exclusive",     both, 0);
        check("sim_r0_rdata",      r0_rdata, 32'h0000_AAAA);
        check("sim_r1_rdata",      r1_rdata, 32'h0000_BBBB);

        // ---- sustained contention for six accesses
`ifdef MEM_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
        r0_req = 1; r1_req = 1;
        n = 0; both = 0;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
            tick();
            if (r0_gnt && r1_gnt) both++;
            if (r0_gnt) begin seq[n] = 0; n++; end
            else if (r1_gnt) begin seq[n] = 1; n++; end
        end
        r0_req = 0; r1_req = 0;
        check("cont_grants", n, 6);
        check("cont_exclusive", both, 0);
        for (int i = 0; i < 6; i++)
            check($sformatf("cont_seq%0d", i), (i < n) ? seq[i] : -1, exp_seq[i]);
        tick();                                  // RESP
        tick();                                  // IDLE

        // ---- reset during ACCESS of a write to 0xFFF
        r0_req = 1; r0_we = 1; r0_addr = 12'hFFF; r0_wdata = 32'hBAD0_BAD0;
        tick();                                  // ACCESS
        check("abort_mem_we_before", mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_we_now",  mem_we,   0);
        check("abort_gnt",         r0_gnt,   0);
        check("abort_mem_addr",    mem_addr, 0);
        check("abort_rdata",       r0_rdata, 0);
        r0_req = 0; r0_we = 0;
        tick();
        check("abort_mem_kept", mem[12'hFFF], 32'h1234_5678);

        // ---- first sample on first edge after release; then r0 read of 0xFFF
        r1_req = 1; r1_we = 0; r1_addr = 12'h010;
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_r1_gnt", r1_gnt, 1);
        r1_req = 0;
        tick();
        check("post_rst_r1_rdata", r1_rdata, 32'hDEAD_BEEF);
        tick();                                  // IDLE

        r0_req = 1; r0_we = 0; r0_addr = 12'hFFF; // request cycle
        t0 = -1; both = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            if (r0_gnt) r0_req = 0;
            if (r1_rvalid || r1_gnt) both++;
            if (r0_rvalid && t0 < 0) t0 = cyc;
        end
        // request, grant and rvalid occupy three consecutive cycles
        check("ffff_rvalid_cyc",   t0, 2);
        check("ffff_r0_rdata",     r0_rdata, 32'h1234_5678);
        check("ffff_r1_rdata",     r1_rdata, 32'hDEAD_BEEF);
        check("ffff_r1_quiet",     both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
